// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32 execute stage -- operand-B mux, ALU operation decode and a
// 32-bit integer ALU with a registered result and zero flag.
// Optional feature macro: ALU_BRANCH_CMP_EN. When defined, BRANCH opcodes decode
// to dedicated compare operations producing a 0/1 taken value. When undefined,
// branches decode to SUB and branch resolution relies on the zero flag.

module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] operand_b,
    output logic [3:0]  alu_decode,
    output logic [31:0] result,
    output logic        zero
);

    // Decoded operation codes
    localparam logic [3:0] OpAdd   = 4'd0;
    localparam logic [3:0] OpSub   = 4'd1;
    localparam logic [3:0] OpSll   = 4'd2;
    localparam logic [3:0] OpSlt   = 4'd3;
    localparam logic [3:0] OpSltu  = 4'd4;
    localparam logic [3:0] OpXor   = 4'd5;
    localparam logic [3:0] OpSrl   = 4'd6;
    localparam logic [3:0] OpSra   = 4'd7;
    localparam logic [3:0] OpOr    = 4'd8;
    localparam logic [3:0] OpAnd   = 4'd9;
    localparam logic [3:0] OpPassB = 4'd10;
    localparam logic [3:0] OpBeq   = 4'd11;
    localparam logic [3:0] OpBne   = 4'd12;
    localparam logic [3:0] OpBge   = 4'd13;
    localparam logic [3:0] OpBgeu  = 4'd14;
    localparam logic [3:0] OpRsvd  = 4'd15;

    // Control-unit ALU opcodes
    localparam logic [3:0] AluMem    = 4'b0000;
    localparam logic [3:0] AluBranch = 4'b0001;
    localparam logic [3:0] AluRtype  = 4'b0010;
    localparam logic [3:0] AluItype  = 4'b0011;
    localparam logic [3:0] AluLui    = 4'b0100;

    logic [2:0]  funct3;
    logic        bit30;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] result_q;
    logic        zero_q;

    assign funct3 = instruction[14:12];
    assign bit30  = instruction[30];

    // Instruction bits outside funct3 and bit 30 are not needed here
    logic unused_instr;
    assign unused_instr = ^{instruction[31], instruction[29:15], instruction[11:0]};

    // Operand-B selection: register or immediate
    always_comb begin
        operand_b = alu_src ? imm : rs2_data;
    end

    // Operation decode from ALU opcode and funct fields
    always_comb begin
        alu_decode = OpAdd;
        unique case (alu_op)
            AluMem: alu_decode = OpAdd;
            AluBranch: begin
`ifdef ALU_BRANCH_CMP_EN
                case (funct3)
                    3'b000:  alu_decode = OpBeq;
                    3'b001:  alu_decode = OpBne;
                    3'b100:  alu_decode = OpSlt;
                    3'b101:  alu_decode = OpBge;
                    3'b110:  alu_decode = OpSltu;
                    3'b111:  alu_decode = OpBgeu;
                    default: alu_decode = OpRsvd;
                endcase
`else
                alu_decode = OpSub;
`endif
            end
            AluRtype, AluItype: begin
                case (funct3)
                    // I-type never subtracts; bit 30 is part of the immediate there
                    3'b000:  alu_decode = (bit30 && alu_op == AluRtype) ? OpSub : OpAdd;
                    3'b001:  alu_decode = OpSll;
                    3'b010:  alu_decode = OpSlt;
                    3'b011:  alu_decode = OpSltu;
                    3'b100:  alu_decode = OpXor;
                    3'b101:  alu_decode = bit30 ? OpSra : OpSrl;
                    3'b110:  alu_decode = OpOr;
                    default: alu_decode = OpAnd;
                endcase
            end
            AluLui:  alu_decode = OpPassB;
            default: alu_decode = OpAdd;
        endcase
    end

    assign shamt = operand_b[4:0];

    // Combinational ALU datapath
    always_comb begin
        alu_res = '0;
        unique case (alu_decode)
            OpAdd:   alu_res = rs1_data + operand_b;
            OpSub:   alu_res = rs1_data - operand_b;
            OpSll:   alu_res = rs1_data << shamt;
            OpSlt:   alu_res = {31'd0, $signed(rs1_data) < $signed(operand_b)};
            OpSltu:  alu_res = {31'd0, rs1_data < operand_b};
            OpXor:   alu_res = rs1_data ^ operand_b;
            OpSrl:   alu_res = rs1_data >> shamt;
            OpSra:   alu_res = $unsigned($signed(rs1_data) >>> shamt);
            OpOr:    alu_res = rs1_data | operand_b;
            OpAnd:   alu_res = rs1_data & operand_b;
            OpPassB: alu_res = operand_b;
            OpBeq:   alu_res = {31'd0, rs1_data == operand_b};
            OpBne:   alu_res = {31'd0, rs1_data != operand_b};
            OpBge:   alu_res = {31'd0, $signed(rs1_data) >= $signed(operand_b)};
            OpBgeu:  alu_res = {31'd0, rs1_data >= operand_b};
            default: alu_res = '0;
        endcase
    end

    // Result and zero flag registers; synchronous active-low reset wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= alu_res;
            zero_q   <= (alu_res == '0);
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed plan cases plus randomized
// traffic checked against a behavioural model. Honours ALU_BRANCH_CMP_EN.

module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] operand_b;
    logic [3:0]  alu_decode;
    logic [31:0] result;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .imm         (imm),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .operand_b   (operand_b),
        .alu_decode  (alu_decode),
        .result      (result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Spec-level decode table
    function automatic logic [3:0] ref_decode(input logic [3:0] op, input logic [2:0] f3,
                                              input logic b30);
        logic [3:0] base [8];
        base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (op == 4'd1) begin
`ifdef ALU_BRANCH_CMP_EN
            if (f3 == 3'd0) return 4'd11;
            if (f3 == 3'd1) return 4'd12;
            if (f3 == 3'd4) return 4'd3;
            if (f3 == 3'd5) return 4'd13;
            if (f3 == 3'd6) return 4'd4;
            if (f3 == 3'd7) return 4'd14;
            return 4'd15;
`else
            return 4'd1;
`endif
        end
        if (op == 4'd2 || op == 4'd3) begin
            if (b30 && f3 == 3'd5) return 4'd7;
            if (b30 && f3 == 3'd0 && op == 4'd2) return 4'd1;
            return base[f3];
        end
        if (op == 4'd4) return 4'd10;
        return 4'd0;
    endfunction

    // Arithmetic model using wide signed integers
    function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a,
                                            input logic [31:0] b);
        longint ua, ub, sa, sb;
        int     s;
        logic [31:0] fill;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = ua - (a[31] ? 64'sd4294967296 : 64'sd0);
        sb = ub - (b[31] ? 64'sd4294967296 : 64'sd0);
        s  = int'(ub % 32);
        fill = a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0;
        case (code)
            4'd0:  return 32'(ua + ub);
            4'd1:  return 32'(ua - ub);
            4'd2:  return 32'(ua * (64'sd1 << s));
            4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return 32'(ua / (64'sd1 << s));
            4'd7:  return 32'(ua / (64'sd1 << s)) | fill;
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            4'd11: return (ua == ub) ? 32'd1 : 32'd0;
            4'd12: return (ua != ub) ? 32'd1 : 32'd0;
            4'd13: return (sa >= sb) ? 32'd1 : 32'd0;
            4'd14: return (ua >= ub) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one operation after a falling edge, check combinational outputs, then the
    // registered result after the next rising edge.
    task automatic apply(input string tag, input logic [3:0] op, input logic [2:0] f3,
                         input logic b30, input logic src, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ins, exp_b, exp_r;
        logic [3:0]  exp_d;
        @(negedge clk);
        ins         = $urandom;
        ins[14:12]  = f3;
        ins[30]     = b30;
        instruction = ins;
        alu_op      = op;
        alu_src     = src;
        imm         = im;
        rs1_data    = a;
        rs2_data    = b;
        #1;
        exp_b = src ? im : b;
        exp_d = ref_decode(op, f3, b30);
        exp_r = ref_alu(exp_d, a, exp_b);
        check({tag, "_opb"}, operand_b, exp_b);
        check({tag, "_dec"}, {28'd0, alu_decode}, {28'd0, exp_d});
        @(posedge clk);
        #1;
        if (!reset) begin
            exp_r = 32'd0;
        end
        check({tag, "_res"}, result, exp_r);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_r == 32'd0});
    endtask

    initial begin
        reset       = 1'b0;
        instruction = '0;
        alu_op      = '0;
        alu_src     = 1'b0;
        imm         = '0;
        rs1_data    = '0;
        rs2_data    = '0;

        // Reset holds result at 0 even with a live ADD presented
        apply("rst_hold", 4'd2, 3'd0, 1'b0, 1'b0, 32'd0, 32'd5, 32'd3);
        apply("rst_hold2", 4'd2, 3'd0, 1'b0, 1'b0, 32'd0, 32'd5, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        apply("rst_rel", 4'd2, 3'd0, 1'b0, 1'b0, 32'd0, 32'd5, 32'd3);
        check("rst_rel_8", result, 32'd8);

        // R-type
        apply("r_sub", 4'd2, 3'd0, 1'b1, 1'b0, 32'd0, 32'd10, 32'd10);
        check("r_sub_dec", {28'd0, alu_decode}, 32'd1);
        check("r_sub_z", {31'd0, zero}, 32'd1);
        apply("r_sra", 4'd2, 3'd5, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'd4);
        check("r_sra_v", result, 32'hF800_0000);
        apply("r_ovf", 4'd2, 3'd0, 1'b0, 1'b0, 32'd0, 32'h7FFF_FFFF, 32'd1);
        check("r_ovf_v", result, 32'h8000_0000);
        apply("r_sll37", 4'd2, 3'd1, 1'b0, 1'b0, 32'd0, 32'd1, 32'h25);
        check("r_sll37_v", result, 32'h20);
        apply("r_slt_min", 4'd2, 3'd2, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd1);
        check("r_slt_min_v", result, 32'd1);
        apply("r_sltu_min", 4'd2, 3'd3, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'd1);
        check("r_sltu_min_v", result, 32'd0);

        // I-type
        apply("i_add", 4'd3, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd77);
        check("i_add_v", result, 32'd0);
        apply("i_srai", 4'd3, 3'd5, 1'b1, 1'b1, 32'h4000_041F, 32'h8000_0000, 32'd0);
        check("i_srai_v", result, 32'hFFFF_FFFF);

        // Signed vs unsigned compare
        apply("slt", 4'd2, 3'd2, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd1);
        check("slt_v", result, 32'd1);
        apply("sltu", 4'd2, 3'd3, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd1);
        check("sltu_v", result, 32'd0);

        // Branch decode
`ifdef ALU_BRANCH_CMP_EN
        apply("blt", 4'd1, 3'd4, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd1);
        check("blt_v", result, 32'd1);
        apply("bgeu", 4'd1, 3'd7, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd1);
        check("bgeu_v", result, 32'd1);
        apply("beq", 4'd1, 3'd0, 1'b0, 1'b0, 32'd0, 32'd7, 32'd7);
        check("beq_dec", {28'd0, alu_decode}, 32'd11);
        check("beq_v", result, 32'd1);
`else
        apply("beq", 4'd1, 3'd0, 1'b0, 1'b0, 32'd0, 32'd7, 32'd7);
        check("beq_dec", {28'd0, alu_decode}, 32'd1);
        check("beq_v", result, 32'd0);
        check("beq_z", {31'd0, zero}, 32'd1);
`endif

        // LUI and default opcode
        apply("lui", 4'd4, 3'd3, 1'b0, 1'b1, 32'h1234_5000, 32'd99, 32'd1);
        check("lui_v", result, 32'h1234_5000);
        apply("dflt", 4'd15, 3'd1, 1'b1, 1'b0, 32'd0, 32'd2, 32'd3);
        check("dflt_v", result, 32'd5);

        // Reset asserted mid-stream overrides a nonzero computation
        reset = 1'b0;
        apply("rst_mid", 4'd2, 3'd6, 1'b0, 1'b0, 32'd0, 32'hF0F0_0000, 32'h0000_0F0F);
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            apply("rnd", 4'($urandom_range(0, 15)), 3'($urandom), 1'($urandom),
                  1'($urandom), $urandom, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
